// File: rtl/raisin64_mem_pkg.sv
// Shared encodings for the data-memory responder: access widths, sequencer
// states and the small alignment/mask helpers used by both responder files.
package raisin64_mem_pkg;

  localparam logic [1:0] WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] WIDTH_HALF  = 2'b01;
  localparam logic [1:0] WIDTH_WORD  = 2'b10;
  localparam logic [1:0] WIDTH_DWORD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WAIT,
    S_DONE
  } dmem_state_e;

  function automatic logic is_misaligned(input logic [1:0] width, input logic [2:0] offset);
    case (width)
      WIDTH_HALF:  is_misaligned = offset[0];
      WIDTH_WORD:  is_misaligned = |offset[1:0];
      WIDTH_DWORD: is_misaligned = |offset;
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: size_mask = 64'h0000_0000_0000_00FF;
      WIDTH_HALF: size_mask = 64'h0000_0000_0000_FFFF;
      WIDTH_WORD: size_mask = 64'h0000_0000_FFFF_FFFF;
      default:    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane logic: pulls the addressed bytes out of a 64-bit word
// (zero-extended) and builds the read-modify-write word for sub-dword stores.
module dmem_lane_align
  import raisin64_mem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  offset,
  input  logic [1:0]  width,
  input  logic [63:0] wdata,
  output logic [63:0] rdata_ext,
  output logic [63:0] merged
);

  logic [5:0]  shamt;
  logic [63:0] mask;

  assign shamt     = {offset, 3'b000};
  assign mask      = size_mask(width);
  assign rdata_ext = (word >> shamt) & mask;
  assign merged    = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one pipeline load/store at a time, runs it
// against a single-port synchronous RAM and signals a one-cycle completion.
module dmem_responder
  import raisin64_mem_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          dmem_addr,
  input  logic [63:0]          dmem_dout,
  input  logic [1:0]           dmem_write_width,
  input  logic                 dmem_rstrobe,
  input  logic                 dmem_wstrobe,
  output logic [63:0]          dmem_din,
  output logic                 dmem_cycle_complete,
  output logic                 dmem_fault,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic [ADDR_BITS-4:0] ram_addr,
  output logic [63:0]          ram_wdata,
  input  logic [63:0]          ram_rdata
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_e          state_q, state_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [63:0]          dout_q, dout_d;
  logic [1:0]           width_q, width_d;
  logic                 is_write_q, is_write_d;
  logic                 fault_q, fault_d;
  logic                 rd_capture_q, rd_capture_d;
  logic [63:0]          din_q, din_d;
  logic                 req_valid, req_fault;
  logic [63:0]          lane_rdata, lane_merged;

  assign req_valid = dmem_rstrobe | dmem_wstrobe;
  assign req_fault = (dmem_rstrobe & dmem_wstrobe)
                   | is_misaligned(dmem_write_width, dmem_addr[2:0])
                   | (|(dmem_addr >> ADDR_BITS));

  dmem_lane_align u_lane_align (
    .word      (ram_rdata),
    .offset    (addr_q[2:0]),
    .width     (width_q),
    .wdata     (dout_q),
    .rdata_ext (lane_rdata),
    .merged    (lane_merged)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    width_d      = width_q;
    is_write_d   = is_write_q;
    fault_d      = fault_q;
    rd_capture_d = 1'b0;
    // RAM read data is valid the cycle after RD, so it is captured one edge later
    din_d        = rd_capture_q ? lane_rdata : din_q;

    case (state_q)
      // DONE also samples strobes so back-to-back requests see no extra gap
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (req_valid) begin
          addr_d     = dmem_addr[ADDR_BITS-1:0];
          dout_d     = dmem_dout;
          width_d    = dmem_write_width;
          is_write_d = dmem_wstrobe;
          fault_d    = req_fault;
          if (req_fault) begin
            state_d = S_DONE;
            din_d   = '0;
          end else if (dmem_wstrobe && dmem_write_width == WIDTH_DWORD) begin
            state_d = S_MERGE;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        rd_capture_d = ~is_write_q;
        if (is_write_q) begin
          state_d = S_MERGE;
        end else if (WAIT_STATES == 0) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      S_MERGE: begin
        if (WAIT_STATES == 0) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
      width_q      <= '0;
      is_write_q   <= 1'b0;
      fault_q      <= 1'b0;
      rd_capture_q <= 1'b0;
      din_q        <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      width_q      <= width_d;
      is_write_q   <= is_write_d;
      fault_q      <= fault_d;
      rd_capture_q <= rd_capture_d;
      din_q        <= din_d;
    end
  end

  assign ram_cs              = (state_q == S_RD) || (state_q == S_MERGE);
  assign ram_we              = (state_q == S_MERGE);
  assign ram_addr            = addr_q[ADDR_BITS-1:3];
  assign ram_wdata           = (state_q != S_MERGE)     ? '0
                             : (width_q == WIDTH_DWORD) ? dout_q
                             : lane_merged;
  assign dmem_cycle_complete = (state_q == S_DONE);
  assign dmem_fault          = (state_q == S_DONE) && fault_q;
  assign dmem_din            = din_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) share stimulus;
// a byte-array reference model supplies expected data, latency and RAM activity.
module tb_dmem_responder;
  import raisin64_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] addr = '0, dout = '0;
  logic [1:0]  width = '0;
  logic        rs = 1'b0, ws = 1'b0;

  logic [63:0] din0, wd0, rd0, din3, wd3, rd3;
  logic        cc0, flt0, cs0, we0, cc3, flt3, cs3, we3;
  logic [4:0]  ra0, ra3;

  logic        bd_we = 1'b0;
  logic [4:0]  bd_idx = '0;
  logic [63:0] bd_data = '0;
  logic [63:0] mem0 [32];
  logic [63:0] mem3 [32];
  logic [7:0]  ref_bytes [256];
  logic [63:0] ref_din;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .dmem_addr(addr), .dmem_dout(dout), .dmem_write_width(width),
    .dmem_rstrobe(rs), .dmem_wstrobe(ws), .dmem_din(din0), .dmem_cycle_complete(cc0),
    .dmem_fault(flt0), .ram_cs(cs0), .ram_we(we0), .ram_addr(ra0), .ram_wdata(wd0), .ram_rdata(rd0)
  );

  dmem_responder #(.ADDR_BITS(8), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .dmem_addr(addr), .dmem_dout(dout), .dmem_write_width(width),
    .dmem_rstrobe(rs), .dmem_wstrobe(ws), .dmem_din(din3), .dmem_cycle_complete(cc3),
    .dmem_fault(flt3), .ram_cs(cs3), .ram_we(we3), .ram_addr(ra3), .ram_wdata(wd3), .ram_rdata(rd3)
  );

  // Synchronous single-port RAMs plus a backdoor load port shared by both
  always @(posedge clk) begin
    if (bd_we) begin
      mem0[bd_idx] <= bd_data;
      mem3[bd_idx] <= bd_data;
    end
    if (cs0) begin
      if (we0) mem0[ra0] <= wd0;
      else     rd0 <= mem0[ra0];
    end
    if (cs3) begin
      if (we3) mem3[ra3] <= wd3;
      else     rd3 <= mem3[ra3];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge
  task automatic preload(input bit fixed_w0);
    for (int i = 0; i < 32; i++) begin
      logic [63:0] v;
      v = {$urandom, $urandom};
      if (fixed_w0 && i == 0) v = 64'h8877665544332211;
      bd_idx = 5'(i); bd_data = v; bd_we = 1'b1;
      for (int b = 0; b < 8; b++) ref_bytes[i*8+b] = v[b*8 +: 8];
      @(negedge clk);
    end
    bd_we = 1'b0;
  endtask

  function automatic logic [63:0] ref_word(input int idx);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) v[b*8 +: 8] = ref_bytes[idx*8+b];
    return v;
  endfunction

  // Reference rules: fault checks, latency by kind, byte-wise memory update
  task automatic model(input logic r, input logic w, input logic [1:0] wd, input logic [63:0] a,
                       input logic [63:0] d, output logic ef, output int base,
                       output logic [63:0] ed, output int ecs, output int ewe);
    int nb;
    nb  = 1 << wd;
    ef  = (r && w) || (a % 64'(nb) != 0) || (a > 64'd255);
    ed  = ref_din;
    ewe = 0;
    if (ef) begin
      base = 1; ed = '0; ecs = 0;
    end else if (r) begin
      base = 2; ecs = 1; ed = '0;
      for (int i = 0; i < nb; i++) ed[i*8 +: 8] = ref_bytes[int'(a) + i];
    end else begin
      base = (nb == 8) ? 2 : 3;
      ecs  = (nb == 8) ? 1 : 2;
      ewe  = 1;
      for (int i = 0; i < nb; i++) ref_bytes[int'(a) + i] = d[i*8 +: 8];
    end
    ref_din = ed;
  endtask

  // Apply one request at the next edge (T0) and measure both instances
  task automatic run_txn(input string nm, input logic r, input logic w, input logic [1:0] wd,
                         input logic [63:0] a, input logic [63:0] d, input logic ef,
                         input int el0, input int el3, input logic [63:0] ed,
                         input int ecs, input int ewe);
    int lat0, lat3, c0, c3, w0n, w3n;
    logic f0, f3;
    lat0 = -1; lat3 = -1; c0 = 0; c3 = 0; w0n = 0; w3n = 0; f0 = 1'bx; f3 = 1'bx;
    addr = a; dout = d; width = wd; rs = r; ws = w;
    @(posedge clk);
    #1; rs = 1'b0; ws = 1'b0;
    for (int k = 1; k <= 25 && (lat0 < 0 || lat3 < 0); k++) begin
      @(negedge clk);
      if (cs0) c0++;
      if (cs0 && we0) w0n++;
      if (cs3) c3++;
      if (cs3 && we3) w3n++;
      if (cc0 && lat0 < 0) begin lat0 = k; f0 = flt0; end
      if (cc3 && lat3 < 0) begin lat3 = k; f3 = flt3; end
    end
    @(negedge clk);
    chk({nm, ".lat0"}, 64'(lat0), 64'(el0));
    chk({nm, ".lat3"}, 64'(lat3), 64'(el3));
    chk({nm, ".fault0"}, 64'(f0), 64'(ef));
    chk({nm, ".fault3"}, 64'(f3), 64'(ef));
    chk({nm, ".din0"}, din0, ed);
    chk({nm, ".din3"}, din3, ed);
    chk({nm, ".cs0"}, 64'(c0), 64'(ecs));
    chk({nm, ".cs3"}, 64'(c3), 64'(ecs));
    chk({nm, ".we0"}, 64'(w0n), 64'(ewe));
    chk({nm, ".we3"}, 64'(w3n), 64'(ewe));
    chk({nm, ".pulse_end"}, 64'({cc0, cc3}), 64'd0);
    $display("txn %s r=%0b w=%0b wd=%0d a=%h d=%h lat0=%0d lat3=%0d din0=%h",
             nm, r, w, wd, a, d, lat0, lat3, din0);
  endtask

  typedef struct {
    string       nm;
    logic        r, w;
    logic [1:0]  wd;
    logic [63:0] a, d;
    logic        ef;
    int          lat;
    logic [63:0] ed;
    int          ecs, ewe;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [63:0] w1_before, ed;
    logic        ef;
    int          base, ecs, ewe, lat0, lat3, c0;
    string       nm;

    vecs[0] = '{"rd_b3",    1'b1, 1'b0, WIDTH_BYTE,  64'h3,   64'h0, 1'b0, 2, 64'h44, 1, 0};
    vecs[1] = '{"wr_h2",    1'b0, 1'b1, WIDTH_HALF,  64'h2,   64'hBEEF, 1'b0, 3, 64'h44, 2, 1};
    vecs[2] = '{"wr_d10",   1'b0, 1'b1, WIDTH_DWORD, 64'h10,  64'h0123456789ABCDEF, 1'b0, 2, 64'h44, 1, 1};
    vecs[3] = '{"rd_d10",   1'b1, 1'b0, WIDTH_DWORD, 64'h10,  64'h0, 1'b0, 2, 64'h0123456789ABCDEF, 1, 0};
    vecs[4] = '{"rd_w6",    1'b1, 1'b0, WIDTH_WORD,  64'h6,   64'h0, 1'b1, 1, 64'h0, 0, 0};
    vecs[5] = '{"rd_b100",  1'b1, 1'b0, WIDTH_BYTE,  64'h100, 64'h0, 1'b1, 1, 64'h0, 0, 0};
    vecs[6] = '{"rd_w4",    1'b1, 1'b0, WIDTH_WORD,  64'h4,   64'h0, 1'b0, 2, 64'h88776655, 1, 0};
    vecs[7] = '{"rd_h2",    1'b1, 1'b0, WIDTH_HALF,  64'h2,   64'h0, 1'b0, 2, 64'hBEEF, 1, 0};
    vecs[8] = '{"wr_b_oob", 1'b0, 1'b1, WIDTH_BYTE,  64'h1_0000_0000, 64'h5A, 1'b1, 1, 64'h0, 0, 0};
    vecs[9] = '{"rd_w0",    1'b1, 1'b0, WIDTH_WORD,  64'h0,   64'h0, 1'b0, 2, 64'hBEEF2211, 1, 0};

    #3;
    chk("rst.din", din0, 64'd0);
    chk("rst.complete", 64'(cc0), 64'd0);
    chk("rst.fault", 64'(flt0), 64'd0);
    chk("rst.cs_we", 64'({cs0, we0, cs3, we3}), 64'd0);
    chk("rst.addr_wdata", {59'd0, ra0} | wd0, 64'd0);
    @(negedge clk);
    preload(1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].nm, vecs[i].r, vecs[i].w, vecs[i].wd, vecs[i].a, vecs[i].d, vecs[i].ef,
              vecs[i].lat, vecs[i].ef ? 1 : vecs[i].lat + 3, vecs[i].ed, vecs[i].ecs, vecs[i].ewe);
    chk("mem0.w0", mem0[0], 64'h88776655BEEF2211);
    chk("mem3.w0", mem3[0], 64'h88776655BEEF2211);
    chk("mem0.w2", mem0[2], 64'h0123456789ABCDEF);

    // Both strobes fault; read held through DONE is re-accepted at that edge
    addr = 64'h0; width = WIDTH_BYTE; rs = 1'b1; ws = 1'b1;
    @(posedge clk); #1 ws = 1'b0;
    @(negedge clk);
    chk("both.complete", 64'({cc0, flt0, cc3, flt3}), 64'hF);
    chk("both.din", din0, 64'd0);
    @(posedge clk); #1 rs = 1'b0;
    lat0 = -1; lat3 = -1; c0 = 0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (cs0) c0++;
      if (cc0 && lat0 < 0) begin lat0 = k; chk("held.fault0", 64'(flt0), 64'd0); end
      if (cc3 && lat3 < 0) begin lat3 = k; chk("held.fault3", 64'(flt3), 64'd0); end
    end
    chk("held.lat0", 64'(lat0), 64'd3);
    chk("held.lat3", 64'(lat3), 64'd6);
    chk("held.cs0", 64'(c0), 64'd1);
    chk("held.din", {din0, din3} , {64'h11, 64'h11});
    $display("txn held_read lat0=%0d lat3=%0d din0=%h", lat0, lat3, din0);

    // Reset during the MERGE cycle of a byte write
    w1_before = mem0[1];
    addr = 64'h9; dout = 64'hAA; width = WIDTH_BYTE; ws = 1'b1;
    @(posedge clk); #1 ws = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstm.in_merge", 64'({cs0, we0, cs3, we3}), 64'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("rstm.ram", 64'({cs0, we0, cs3, we3}), 64'd0);
    chk("rstm.wdata", wd0 | wd3, 64'd0);
    chk("rstm.din", din0 | din3, 64'd0);
    chk("rstm.complete", 64'({cc0, flt0, cc3, flt3}), 64'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rstm.no_pulse", 64'({cc0, cc3}), 64'd0);
    end
    chk("rstm.mem0", mem0[1], w1_before);
    chk("rstm.mem3", mem3[1], w1_before);
    $display("txn reset_in_merge word1=%h", mem0[1]);
    run_txn("post_rst_rd", 1'b1, 1'b0, WIDTH_BYTE, 64'h9, 64'h0, 1'b0, 2, 5,
            (w1_before >> 8) & 64'hFF, 1, 0);

    // Randomized phase against the byte-array model
    preload(1'b0);
    ref_din = din0;
    for (int n = 0; n < 60; n++) begin
      logic r, w;
      logic [1:0] wd;
      logic [63:0] a, d;
      int sel;
      sel = $urandom_range(0, 9);
      r = (sel <= 4) || (sel == 9);
      w = (sel >= 5);
      wd = 2'($urandom_range(0, 3));
      a = 64'($urandom_range(0, 255)) & ~64'((1 << wd) - 1);
      sel = $urandom_range(0, 19);
      if (sel < 3) a = 64'($urandom_range(0, 255));
      else if (sel == 3) a = 64'h100 + 64'($urandom_range(0, 255));
      else if (sel == 4) a = a | (64'h1 << $urandom_range(8, 63));
      d = {$urandom, $urandom};
      model(r, w, wd, a, d, ef, base, ed, ecs, ewe);
      nm = $sformatf("rnd%0d", n);
      run_txn(nm, r, w, wd, a, d, ef, base, ef ? 1 : base + 3, ed, ecs, ewe);
    end
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("final.mem0[%0d]", i), mem0[i], ref_word(i));
      chk($sformatf("final.mem3[%0d]", i), mem3[i], ref_word(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
